// File: rtl/game_pkg.sv
// Shared game-state types: pipe record layout and list operation codes.
package game_pkg;

  localparam int PIPE_X_W = 12;
  localparam int PIPE_Y_W = 11;

  // x is the left edge and may scroll past the screen edge; y is the top-pipe height
  typedef struct packed {
    logic signed [PIPE_X_W-1:0] x;
    logic        [PIPE_Y_W-1:0] y;
  } pipe_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_INSERT,
    OP_START,
    OP_REMOVE,
    OP_STEP
  } list_op_e;

endpackage

// File: rtl/lfsr_range_gen.sv
// 16-bit Galois LFSR whose low bits are filtered into a bounded output range.
module lfsr_range_gen #(
  parameter int          OUT_W   = 9,
  parameter int          OUT_MIN = 1,
  parameter int          OUT_MAX = 280,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [OUT_W-1:0] rng_out
);

  localparam logic [15:0] TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  function automatic logic in_range(input logic [OUT_W-1:0] v);
    return (v >= OUT_W'(OUT_MIN)) && (v <= OUT_W'(OUT_MAX));
  endfunction

  logic [15:0]      lfsr;
  logic [15:0]      lfsr_nxt;
  logic [OUT_W-1:0] cand;

  assign lfsr_nxt = lfsr_step(lfsr);
  assign cand     = OUT_W'(lfsr_nxt);

  // Out-of-range candidates are skipped, so rng_out keeps its previous legal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr    <= SEED;
      rng_out <= OUT_W'(OUT_MIN);
    end else if (ce) begin
      lfsr <= lfsr_nxt;
      if (in_range(cand)) rng_out <= cand;
    end
  end

endmodule

// File: rtl/pipes_list_rng.sv
// Compacted pipe list with one streaming iterator (read / write-back / remove),
// plus the gap-height random generator.
module pipes_list_rng
  import game_pkg::*;
#(
  parameter int          CAPACITY      = 8,
  parameter int          RNG_OUT_WIDTH = 9,
  parameter int          RNG_OUT_MIN   = 1,
  parameter int          RNG_OUT_MAX   = 280,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     list_ce,
  input  logic                     rng_ce,
  output logic [4:0]               count,
  input  logic                     insert_en,
  input  pipe_t                    insert_data,
  input  logic                     iter_start,
  input  pipe_t                    iter_in,
  output pipe_t                    iter_out,
  output logic                     iter_out_valid,
  input  logic                     iter_remove,
  output logic [RNG_OUT_WIDTH-1:0] rng_out
);

  pipe_t      mem [CAPACITY];
  logic [4:0] cursor;
  logic [4:0] nxt_idx;
  logic       more_left;
  logic       not_full;
  list_op_e   op;

  function automatic pipe_t entry_at(input logic [4:0] i);
    pipe_t r;
    r = '0;
    for (int k = 0; k < CAPACITY; k++) begin
      if (5'(k) == i) r = mem[k];
    end
    return r;
  endfunction

  assign nxt_idx   = cursor + 5'd1;
  assign more_left = nxt_idx < count;
  assign not_full  = count < 5'(CAPACITY);

  always_comb begin
    op = OP_NONE;
    if (list_ce) begin
      if (insert_en)                          op = OP_INSERT;
      else if (iter_start)                    op = OP_START;
      else if (iter_out_valid && iter_remove) op = OP_REMOVE;
      else if (iter_out_valid)                op = OP_STEP;
    end
  end

  // Storage is never reset; only count/cursor decide which entries are live
  always_ff @(posedge clk) begin
    case (op)
      OP_INSERT: begin
        for (int k = 0; k < CAPACITY; k++)
          if (not_full && 5'(k) == count) mem[k] <= insert_data;
      end
      OP_REMOVE: begin
        for (int k = 0; k < CAPACITY - 1; k++)
          if (5'(k) >= cursor) mem[k] <= mem[k+1];
      end
      OP_STEP: begin
        for (int k = 0; k < CAPACITY; k++)
          if (5'(k) == cursor) mem[k] <= iter_in;
      end
      default: ;
    endcase
  end

  // Removal keeps the cursor in place: the shifted-down successor becomes current
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count          <= '0;
      cursor         <= '0;
      iter_out       <= '0;
      iter_out_valid <= 1'b0;
    end else begin
      case (op)
        OP_INSERT: begin
          if (not_full) count <= count + 5'd1;
        end
        OP_START: begin
          cursor         <= '0;
          iter_out       <= entry_at('0);
          iter_out_valid <= (count != '0);
        end
        OP_REMOVE: begin
          count <= count - 5'd1;
          if (more_left) iter_out <= entry_at(nxt_idx);
          else           iter_out_valid <= 1'b0;
        end
        OP_STEP: begin
          cursor <= nxt_idx;
          if (more_left) begin
            iter_out <= entry_at(nxt_idx);
          end else begin
            iter_out       <= iter_in;
            iter_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  lfsr_range_gen #(
    .OUT_W  (RNG_OUT_WIDTH),
    .OUT_MIN(RNG_OUT_MIN),
    .OUT_MAX(RNG_OUT_MAX),
    .SEED   (LFSR_SEED)
  ) u_rng (
    .clk    (clk),
    .rst    (rst),
    .ce     (rng_ce),
    .rng_out(rng_out)
  );

endmodule

// File: tb/tb_pipes_list_rng.sv
// Scoreboard bench for pipes_list_rng: list model drives expectations, LFSR model checks the RNG.
module tb_pipes_list_rng;
  import game_pkg::*;

  localparam int CAP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       list_ce;
  logic       rng_ce;
  logic [4:0] count;
  logic       insert_en;
  pipe_t      insert_data;
  logic       iter_start;
  pipe_t      iter_in;
  pipe_t      iter_out;
  logic       iter_out_valid;
  logic       iter_remove;
  logic [8:0] rng_out;

  always #5 clk = ~clk;

  pipes_list_rng #(
    .CAPACITY(CAP), .RNG_OUT_WIDTH(9), .RNG_OUT_MIN(1), .RNG_OUT_MAX(280), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .list_ce(list_ce), .rng_ce(rng_ce), .count(count),
    .insert_en(insert_en), .insert_data(insert_data), .iter_start(iter_start),
    .iter_in(iter_in), .iter_out(iter_out), .iter_out_valid(iter_out_valid),
    .iter_remove(iter_remove), .rng_out(rng_out)
  );

  typedef struct packed {
    pipe_t p;
    logic  v;
  } exp_t;

  exp_t        exp_q[$];
  pipe_t       ref_l[$];
  int          cur;
  pipe_t       mout;
  logic        mvalid;
  logic [15:0] m_lfsr;
  logic [8:0]  m_rng;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic pipe_t mk(input int x, input int y);
    pipe_t r;
    r.x = 12'(x);
    r.y = 11'(y);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp();
    exp_q.push_back('{p: mout, v: mvalid});
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_out"}, 32'(iter_out), 32'(e.p));
      check({tag, "_vld"}, 32'(iter_out_valid), 32'(e.v));
      check({tag, "_cnt"}, 32'(count), 32'(ref_l.size()));
    end
  endtask

  task automatic do_insert(input pipe_t p);
    insert_en   = 1'b1;
    insert_data = p;
    if (ref_l.size() < CAP) ref_l.push_back(p);
    push_exp();
    tick();
    insert_en = 1'b0;
    compare_out("ins");
  endtask

  task automatic do_start();
    iter_start = 1'b1;
    cur        = 0;
    mvalid     = (ref_l.size() != 0);
    if (mvalid) mout = ref_l[0];
    push_exp();
    tick();
    iter_start = 1'b0;
    compare_out("start");
  endtask

  task automatic do_step(input int dx);
    pipe_t w;
    w       = ref_l[cur];
    w.x     = 12'(w.x + dx);
    ref_l[cur] = w;
    cur++;
    if (cur < ref_l.size()) begin
      mout = ref_l[cur];
    end else begin
      mout   = w;
      mvalid = 1'b0;
    end
    iter_in = w;
    push_exp();
    tick();
    compare_out("step");
  endtask

  task automatic do_remove();
    iter_remove = 1'b1;
    ref_l.delete(cur);
    if (cur < ref_l.size()) mout = ref_l[cur];
    else                    mvalid = 1'b0;
    push_exp();
    tick();
    iter_remove = 1'b0;
    compare_out("remove");
  endtask

  task automatic run_iter(input int dx);
    do_start();
    for (int i = 0; i < CAP + 1 && mvalid; i++) do_step(dx);
  endtask

  initial begin
    int changes;
    int in_rng;
    logic [8:0] prev;

    rst = 1'b1; list_ce = 1'b1; rng_ce = 1'b0;
    insert_en = 1'b0; insert_data = '0; iter_start = 1'b0; iter_in = '0; iter_remove = 1'b0;
    mout = '0; mvalid = 1'b0; cur = 0; m_lfsr = 16'hACE1; m_rng = 9'd1;
    tick(); tick();
    rst = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(iter_out_valid), 32'd0);
    check("rst_out", 32'(iter_out), 32'd0);
    check("rst_rng", 32'(rng_out), 32'd1);

    do_insert(mk(639, 10));
    do_insert(mk(500, 20));
    do_insert(mk(400, 30));
    do_start();
    check("first_elem", 32'(iter_out), 32'(mk(639, 10)));
    for (int i = 0; i < 3; i++) do_step(-1);
    check("tail_wb", 32'(iter_out), 32'(mk(399, 30)));
    run_iter(0);

    do_start();
    check("rm_head", 32'(iter_out), 32'(mk(638, 10)));
    do_remove();
    check("rm_next", 32'(iter_out), 32'(mk(499, 20)));
    do_step(0);
    do_remove();
    check("rm_last_hold", 32'(iter_out), 32'(mk(399, 30)));

    // RNG: exact sequence against a reference LFSR, plus range and activity
    changes = 0; in_rng = 0; prev = rng_out;
    rng_ce = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      if (m_lfsr[8:0] >= 9'd1 && m_lfsr[8:0] <= 9'd280) m_rng = m_lfsr[8:0];
      tick();
      check("rng_val", 32'(rng_out), 32'(m_rng));
      if (rng_out >= 9'd1 && rng_out <= 9'd280) in_rng++;
      if (rng_out != prev) changes++;
      prev = rng_out;
    end
    check("rng_in_range", 32'(in_rng), 32'd2000);
    check("rng_changes_ge500", 32'(changes >= 500), 32'd1);
    rng_ce = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rng_hold", 32'(rng_out), 32'(prev));
    end

    // asynchronous reset landing mid-iteration
    do_start();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(iter_out_valid), 32'd0);
    check("arst_out", 32'(iter_out), 32'd0);
    check("arst_rng", 32'(rng_out), 32'd1);
    tick();
    rst = 1'b0;
    ref_l.delete(); exp_q.delete(); mout = '0; mvalid = 1'b0; cur = 0;

    for (int i = 0; i < 9; i++) do_insert(mk(100 + i, i));
    check("full_count", 32'(count), 32'd8);
    run_iter(0);
    check("full_tail", 32'(iter_out), 32'(mk(107, 7)));

    // insert wins over a pending step; the iterator does not move
    do_start();
    do_remove();
    insert_en = 1'b1; insert_data = mk(200, 50); iter_in = mk(0, 0);
    ref_l.push_back(mk(200, 50));
    push_exp();
    tick();
    insert_en = 1'b0;
    compare_out("ins_on_step");
    for (int i = 0; i < CAP + 1 && mvalid; i++) do_step(5);
    check("ins_tail", 32'(iter_out), 32'(mk(205, 50)));

    // list_ce low freezes the iterator and ignores every list input
    do_start();
    do_step(0);
    list_ce = 1'b0; insert_en = 1'b1; insert_data = mk(1, 1); iter_start = 1'b1; iter_in = mk(2, 2);
    for (int i = 0; i < 3; i++) begin
      push_exp();
      tick();
      compare_out("freeze");
    end
    list_ce = 1'b1; insert_en = 1'b0; iter_start = 1'b0;
    for (int i = 0; i < CAP + 1 && mvalid; i++) do_step(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
